fp_sub_issuer: RTL and testbench
================================

// Module: fp_sub_issuer
// PURPOSE
//  Initiator side of the FP-unit enable/stall handshake.
//  Buffers subtract requests in a small FIFO and issues them one at a time to a
//  multi-cycle FP subtract unit. It holds fp_enable and the operands until fp_stall
//  drops, then captures fp_q and returns it with the request tag. Sits between the
//  CPU execute stage and the FP subtract wrapper.
// PARAMETERS
//  DATA_W     16  operand/result width (half precision)
//  TAG_W      4   destination-register tag width
//  DEPTH      4   request FIFO entries; power of two, >=2
//  MAX_STALL  15  stall cycles tolerated per op before timeout (>=2)
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        FIFO can accept (= ~full)
//  req_a        in   DATA_W   minuend
//  req_b        in   DATA_W   subtrahend
//  req_tag      in   TAG_W    destination tag
//  fp_enable    out  1        issue/hold strobe to FP unit
//  fp_a         out  DATA_W   operand A to FP unit
//  fp_b         out  DATA_W   operand B to FP unit
//  fp_q         in   DATA_W   FP unit result
//  fp_stall     in   1        FP unit busy (valid only while fp_enable=1)
//  rsp_valid    out  1        result valid
//  rsp_ready    in   1        consumer accepts result
//  rsp_data     out  DATA_W   captured result
//  rsp_tag      out  TAG_W    tag of the captured result
//  busy         out  1        FSM not IDLE or FIFO non-empty
//  timeout_err  out  1        sticky: an op exceeded MAX_STALL
//  clr_err      in   1        synchronous clear of timeout_err
// BEHAVIOUR
//  Reset (async, reset=0): FIFO empty; state=IDLE. All outputs 0 immediately,
//   except req_ready=1. Reset mid-op abandons the op; no response is produced.
//  FIFO: push on req_valid&&req_ready. Pointers are log2(DEPTH) bits and wrap.
//   An occupancy counter gives full/empty. Full blocks the push even if a pop
//   happens the same cycle. Simultaneous push+pop when not full keeps occupancy.
//  FSM:
//   IDLE: fp_enable=0. If FIFO non-empty, pop head into fp_a/fp_b/op tag,
//    clear stall_cnt, go to ISSUE.
//   ISSUE: fp_enable=1. fp_a/fp_b are held stable.
//    If fp_stall=0: register fp_q->rsp_data and tag->rsp_tag, set rsp_valid,
//     drop fp_enable, go to RESP.
//    Else if stall_cnt==MAX_STALL-1: set timeout_err, drop fp_enable, discard
//     the op (no rsp), go to IDLE.
//    Else stall_cnt++.
//   RESP: fp_enable=0; rsp_valid=1 with data/tag stable. On rsp_ready: clear
//    rsp_valid, go to IDLE.
//  Latency with a 1-cycle FP unit (stall high for the first enable cycle):
//   request accepted at edge E0; fp_enable high after E1; fp_stall low after E2;
//   capture at E3; rsp_valid high after E3.
//   Throughput is one op per 4 cycles with rsp_ready=1.
//  fp_enable always drops for >=1 cycle between ops, so the FP unit returns to idle.
//  timeout_err: set takes priority over a same-cycle clr_err. It is cleared only by
//   clr_err or reset.
//  busy = (state!=IDLE) | ~empty.
// TESTING
//  1. Single op: A=0x4200 (3.0), B=0x3C00 (1.0), tag=5, 1-cycle FP model, rsp_ready=1
//     -> rsp_valid 3 cycles after accept, rsp_data=0x4000, rsp_tag=5, fp_enable
//     high exactly 2 cycles.
//  2. Fill: 5 back-to-back requests, DEPTH=4, FSM blocked (rsp_ready=0)
//     -> 1 issued, then 4 buffered; req_ready=0 on the 6th offer. Releasing
//     rsp_ready drains tags in order 0..4.
//  3. Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/data/tag stable,
//     fp_enable=0 throughout, next op not issued until the handshake.
//  4. Timeout: FP model holds stall=1 forever -> after 15 enable cycles
//     fp_enable=0, timeout_err=1, no rsp, next queued op issues.
//     clr_err pulse -> timeout_err=0.
//  5. Reset mid-ISSUE with 2 queued -> all outputs 0 asynchronously, req_ready=1.
//     After release, busy=0 and no stale rsp_valid.
//  6. Pointer wrap: 9 single ops through DEPTH=4 FIFO -> results and tags
//     match in order.

Source files
------------

// File: rtl/fp_sub_issuer.sv
// Initiator side of the FP-unit enable/stall handshake: queues subtract requests,
// issues them one at a time, and returns each captured result with its tag.
module fp_sub_issuer #(
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              fp_enable,
    output logic [DATA_W-1:0] fp_a,
    output logic [DATA_W-1:0] fp_b,
    input  logic [DATA_W-1:0] fp_q,
    input  logic              fp_stall,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clr_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STL_W = $clog2(MAX_STALL);
    localparam logic [STL_W-1:0] STALL_LAST = STL_W'(MAX_STALL - 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_a_q   [DEPTH];
    logic [DATA_W-1:0] mem_b_q   [DEPTH];
    logic [TAG_W-1:0]  mem_tag_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_s, empty_s, push_s, pop_s;

    // Issue/response state
    state_t            state_q, state_d;
    logic              fp_en_q, fp_en_d;
    logic [DATA_W-1:0] fp_a_q, fp_a_d;
    logic [DATA_W-1:0] fp_b_q, fp_b_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic [STL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              timeout_err_q, timeout_err_d;
    logic              timeout_set_s;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {CNT_W{1'b0}});
    // A full FIFO refuses the push even when the FSM pops in the same cycle.
    assign push_s  = req_valid & ~full_s;
    assign pop_s   = (state_q == ST_IDLE) & ~empty_s;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // FSM next-state, operand hold, stall counting and result capture
    always_comb begin
        state_d       = state_q;
        fp_en_d       = fp_en_q;
        fp_a_d        = fp_a_q;
        fp_b_d        = fp_b_q;
        op_tag_d      = op_tag_q;
        stall_cnt_d   = stall_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        timeout_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fp_en_d = 1'b0;
                if (pop_s) begin
                    fp_a_d      = mem_a_q[rd_ptr_q];
                    fp_b_d      = mem_b_q[rd_ptr_q];
                    op_tag_d    = mem_tag_q[rd_ptr_q];
                    stall_cnt_d = {STL_W{1'b0}};
                    fp_en_d     = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!fp_stall) begin
                    rsp_data_d  = fp_q;
                    rsp_tag_d   = op_tag_q;
                    rsp_valid_d = 1'b1;
                    fp_en_d     = 1'b0;
                    state_d     = ST_RESP;
                end else if (stall_cnt_q == STALL_LAST) begin
                    // Op is abandoned; enable drops so the FP unit can recover.
                    timeout_set_s = 1'b1;
                    fp_en_d       = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + STL_W'(1);
                end
            end
            ST_RESP: begin
                fp_en_d = 1'b0;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                fp_en_d     = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Sticky timeout flag; a new timeout outranks a same-cycle clear
    always_comb begin
        timeout_err_d = timeout_err_q;
        if (timeout_set_s) begin
            timeout_err_d = 1'b1;
        end else if (clr_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i]   <= {DATA_W{1'b0}};
                mem_b_q[i]   <= {DATA_W{1'b0}};
                mem_tag_q[i] <= {TAG_W{1'b0}};
            end
        end else if (push_s) begin
            mem_a_q[wr_ptr_q]   <= req_a;
            mem_b_q[wr_ptr_q]   <= req_b;
            mem_tag_q[wr_ptr_q] <= req_tag;
        end
    end

    // Control and datapath state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            state_q       <= ST_IDLE;
            fp_en_q       <= 1'b0;
            fp_a_q        <= {DATA_W{1'b0}};
            fp_b_q        <= {DATA_W{1'b0}};
            op_tag_q      <= {TAG_W{1'b0}};
            stall_cnt_q   <= {STL_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= {DATA_W{1'b0}};
            rsp_tag_q     <= {TAG_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            fp_en_q       <= fp_en_d;
            fp_a_q        <= fp_a_d;
            fp_b_q        <= fp_b_d;
            op_tag_q      <= op_tag_d;
            stall_cnt_q   <= stall_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready   = ~full_s;
    assign fp_enable   = fp_en_q;
    assign fp_a        = fp_a_q;
    assign fp_b        = fp_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE) | ~empty_s;

endmodule

// File: tb/tb_fp_sub_issuer.sv
// Bench for fp_sub_issuer: a half-precision FP unit model with programmable stall,
// a transaction scoreboard checked every cycle, and directed scenarios with literal pins.
module tb_fp_sub_issuer;
    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int DEPTH     = 4;
    localparam int MAX_STALL = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_a = 16'h0000;
    logic [DATA_W-1:0] req_b = 16'h0000;
    logic [TAG_W-1:0]  req_tag = 4'h0;
    logic              fp_enable;
    logic [DATA_W-1:0] fp_a, fp_b, fp_q;
    logic              fp_stall;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;
    logic              timeout_err;
    logic              clr_err = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_sub_issuer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fp_enable(fp_enable), .fp_a(fp_a), .fp_b(fp_b), .fp_q(fp_q), .fp_stall(fp_stall),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(int'(h[9:0])) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        int   e;
        int   f;
        real  m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        f = int'((m - 1.0) * 1024.0);
        return {s, 5'(e), 10'(f)};
    endfunction

    function automatic logic [15:0] half_sub(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) - h2r(b));
    endfunction

    // FP unit model: stalls for stall_len enable cycles (or forever when hang is set)
    int stall_len = 1;
    bit hang = 1'b0;
    int en_cnt = 0;
    always @(posedge clk) en_cnt <= fp_enable ? en_cnt + 1 : 0;
    assign fp_stall = fp_enable && (hang || (en_cnt < stall_len));
    assign fp_q     = half_sub(fp_a, fp_b);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
    } op_t;

    op_t         exp_q[$];
    logic [15:0] got_data[$];
    logic [3:0]  got_tag[$];
    bit          prev_en = 1'b0;
    bit          stall_low = 1'b0;
    bit          held = 1'b0;
    int          en_run = 0;
    int          occ = 0;
    logic [15:0] held_data;
    logic [3:0]  held_tag;

    // Scoreboard: every request is answered in order, or discarded by a full-length timeout
    always @(negedge clk) begin
        op_t o;
        if (!reset) begin
            exp_q.delete();
            prev_en = 1'b0; stall_low = 1'b0; held = 1'b0; en_run = 0; occ = 0;
        end else begin
            if (fp_enable && !prev_en) occ--;
            if (prev_en && !fp_enable && !rsp_valid) begin
                chk("timeout_len", 32'(en_run), 32'(MAX_STALL));
                chk("timeout_stall_low", 32'(stall_low), 32'd0);
                chk("timeout_flag", 32'(timeout_err), 32'd1);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (!fp_enable) begin
                en_run = 0; stall_low = 1'b0;
            end else begin
                en_run++;
                if (!fp_stall) stall_low = 1'b1;
                if (en_run > MAX_STALL) chk("enable_run", 32'(en_run), 32'(MAX_STALL));
                if (exp_q.size() != 0) begin
                    chk("fp_a", 32'(fp_a), 32'(exp_q[0].a));
                    chk("fp_b", 32'(fp_b), 32'(exp_q[0].b));
                end else begin
                    chk("issue_without_request", 32'(exp_q.size()), 32'd1);
                end
            end
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(occ < DEPTH));
            if (rsp_valid) begin
                chk("enable_in_resp", 32'(fp_enable), 32'd0);
                if (held) begin
                    chk("rsp_data_stable", 32'(rsp_data), 32'(held_data));
                    chk("rsp_tag_stable", 32'(rsp_tag), 32'(held_tag));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() != 0) begin
                    chk("rsp_data", 32'(rsp_data), 32'(half_sub(exp_q[0].a, exp_q[0].b)));
                    chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                    void'(exp_q.pop_front());
                end else begin
                    chk("spurious_rsp", 32'(exp_q.size()), 32'd1);
                end
                got_data.push_back(rsp_data);
                got_tag.push_back(rsp_tag);
            end
            held      = rsp_valid && !rsp_ready;
            held_data = rsp_data;
            held_tag  = rsp_tag;
            if (req_valid && req_ready) begin
                o.a = req_a; o.b = req_b; o.tag = req_tag;
                exp_q.push_back(o);
                occ++;
            end
            prev_en = fp_enable;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (req_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        req_valid = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_got(input int n, input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (got_tag.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_flags"}, 32'({rsp_valid, fp_enable, busy, timeout_err, req_ready}), 32'h01);
        chk({name, "_fp_ab"}, {fp_a, fp_b}, 32'h0);
        chk({name, "_rsp"}, 32'({rsp_data, rsp_tag}), 32'h0);
    endtask

    logic [15:0] t6_a [9];
    logic [15:0] t6_b [9];
    logic [15:0] t6_q [9];

    initial begin
        int          lat, en_hi, en_obs;
        bit          ok;
        logic [15:0] d0;
        logic [3:0]  t0;

        t6_a = '{16'h4200, 16'h4400, 16'h3C00, 16'h4500, 16'h4000, 16'h4800, 16'h3800, 16'h4600, 16'h4900};
        t6_b = '{16'h3C00, 16'h3800, 16'h4000, 16'h4200, 16'h3C00, 16'h4400, 16'h3400, 16'h3C00, 16'h4500};
        t6_q = '{16'h4000, 16'h4300, 16'hBC00, 16'h4000, 16'h3C00, 16'h4400, 16'h3400, 16'h4500, 16'h4500};

        #3;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        tick(); tick();

        // 1: single op, 1-cycle FP unit
        stall_len = 1; rsp_ready = 1'b1;
        send(16'h4200, 16'h3C00, 4'd5);
        lat = -1; en_hi = 0; d0 = 16'h0; t0 = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (fp_enable) en_hi++;
            if (rsp_valid && lat < 0) begin lat = k; d0 = rsp_data; t0 = rsp_tag; end
        end
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_enable_cycles", 32'(en_hi), 32'd2);
        chk("t1_data", 32'(d0), 32'h4000);
        chk("t1_tag", 32'(t0), 32'd5);

        // 2: fill the FIFO behind a blocked response, then drain in order
        got_data.delete(); got_tag.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_a = 16'h4400; req_b = 16'h3C00; req_tag = 4'(i); req_valid = 1'b1;
            chk("t2_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_tag = 4'd5;
        chk("t2_full", 32'(req_ready), 32'd0);
        tick(); tick(); tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_got(5, 80, "t2_drain");
        chk("t2_count", 32'(got_tag.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_tag.size(); i++) chk("t2_order", 32'(got_tag[i]), 32'(i));

        // 3: response held under backpressure for 10 cycles
        got_data.delete(); got_tag.delete();
        rsp_ready = 1'b0;
        send(16'h4500, 16'h4200, 4'd6);
        send(16'h4600, 16'h3C00, 4'd7);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            tick();
        end
        chk("t3_rsp_seen", 32'(ok), 32'd1);
        d0 = rsp_data; t0 = rsp_tag; ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!rsp_valid || rsp_data !== d0 || rsp_tag !== t0 || fp_enable) ok = 1'b0;
        end
        chk("t3_stable", 32'(ok), 32'd1);
        chk("t3_tag", 32'(t0), 32'd6);
        chk("t3_data", 32'(d0), 32'h4000);
        rsp_ready = 1'b1;
        wait_got(2, 30, "t3_drain");
        if (got_tag.size() >= 2) chk("t3_order", 32'({got_tag[0], got_tag[1]}), 32'h67);

        // 4: FP unit never releases stall
        got_data.delete(); got_tag.delete();
        hang = 1'b1;
        send(16'h4000, 16'h3C00, 4'd8);
        send(16'h4600, 16'h3C00, 4'd9);
        en_obs = 0; ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (timeout_err) begin ok = 1'b1; break; end
            if (fp_enable) en_obs++;
            tick();
        end
        chk("t4_timeout_seen", 32'(ok), 32'd1);
        chk("t4_enable_cycles", 32'(en_obs), 32'd15);
        chk("t4_enable_low", 32'(fp_enable), 32'd0);
        chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
        hang = 1'b0;
        tick();
        chk("t4_next_issue", 32'(fp_enable), 32'd1);
        chk("t4_next_a", 32'(fp_a), 32'h4600);
        wait_got(1, 20, "t4_next_rsp");
        chk("t4_sticky", 32'(timeout_err), 32'd1);
        if (got_tag.size() >= 1) chk("t4_rsp_tag", 32'(got_tag[0]), 32'd9);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t4_cleared", 32'(timeout_err), 32'd0);

        // 5: asynchronous reset during ISSUE with two ops queued
        got_data.delete(); got_tag.delete();
        hang = 1'b1;
        send(16'h4200, 16'h3C00, 4'd10);
        send(16'h4400, 16'h3C00, 4'd11);
        send(16'h4500, 16'h3C00, 4'd12);
        chk("t5_in_issue", 32'(fp_enable), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        tick(); tick();
        check_reset_outputs("t5_held");
        hang = 1'b0;
        reset = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy || rsp_valid || fp_enable) ok = 1'b0;
        end
        chk("t5_quiet", 32'(ok), 32'd1);
        chk("t5_no_rsp", 32'(got_tag.size()), 32'd0);

        // 6: nine single ops wrap the FIFO pointers twice
        got_data.delete(); got_tag.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            stall_len = i % 3;
            send(t6_a[i], t6_b[i], 4'(i));
            wait_got(i + 1, 30, "t6_rsp");
        end
        chk("t6_count", 32'(got_tag.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_tag.size(); i++) begin
            chk("t6_tag", 32'(got_tag[i]), 32'(i));
            chk("t6_data", 32'(got_data[i]), 32'(t6_q[i]));
        end

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
